// File: rtl/proj_pkg.sv
// Shared constants and stage bundle for the hasher -> min-k sorter path.
// Stage bundles are sized for the widest supported configuration.
package proj_pkg;

    localparam int unsigned HASHER_SORTER_SIGNATURE = 32;
    localparam int unsigned INDICE_LEN              = 8;

    localparam logic [31:0] HASH_SEED  = 32'h9E37_79B9;
    localparam logic [31:0] HASH_MULT  = 32'h85EB_CA6B;
    localparam int unsigned HASH_SHIFT = 29;

    localparam int unsigned PACK_VALUE_W = 64;
    localparam int unsigned PACK_INDEX_W = 16;

    typedef struct packed {
        logic                    valid;
        logic                    last;
        logic [PACK_INDEX_W-1:0] index;
        logic [PACK_VALUE_W-1:0] value;
    } hasher_stage_pack;

endpackage

// File: rtl/proj_hash_pipe.sv
// Three-stage hash datapath: seed xor, multiply, xor-shift with reserved-value remap.
// valid/last/index ride along unchanged as sideband.
module proj_hash_pipe #(
    parameter int unsigned                 DATA_LEN      = 32,
    parameter int unsigned                 SIGNATURE_LEN = 32,
    parameter int unsigned                 INDICE_LEN    = 8,
    parameter logic [DATA_LEN-1:0]         HASH_SEED     = '0,
    parameter logic [SIGNATURE_LEN-1:0]    HASH_MULT     = 1,
    parameter int unsigned                 HASH_SHIFT    = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic                     last_i,
    input  logic [INDICE_LEN-1:0]    index_i,
    input  logic [DATA_LEN-1:0]      data_i,
    output logic                     valid_o,
    output logic                     last_o,
    output logic [INDICE_LEN-1:0]    index_o,
    output logic [SIGNATURE_LEN-1:0] sig_o
);
    import proj_pkg::*;

    localparam int unsigned PROD_LEN = DATA_LEN + SIGNATURE_LEN;
    localparam logic [SIGNATURE_LEN-1:0] SIG_ALL = '1;

    hasher_stage_pack s1_d, s1_q;
    hasher_stage_pack s2_d, s2_q;
    hasher_stage_pack s3_d, s3_q;

    logic [DATA_LEN-1:0]      x;
    logic [PROD_LEN-1:0]      p_mul;
    logic [PROD_LEN-1:0]      p_in;
    logic [PROD_LEN-1:0]      p_shr;
    logic [SIGNATURE_LEN-1:0] h;
    logic                     unused_pack;

    always_comb begin
        s1_d       = '0;
        s1_d.valid = valid_i;
        s1_d.last  = valid_i & last_i;
        s1_d.index = PACK_INDEX_W'(index_i);
        s1_d.value = PACK_VALUE_W'(data_i ^ HASH_SEED);
    end

    always_comb begin
        x          = s1_q.value[DATA_LEN-1:0];
        p_mul      = PROD_LEN'(x) * PROD_LEN'(HASH_MULT);
        s2_d       = s1_q;
        s2_d.value = PACK_VALUE_W'(p_mul);
    end

    // All-ones is the sorter's idle marker, so a real hash must never produce it.
    always_comb begin
        p_in  = s2_q.value[PROD_LEN-1:0];
        p_shr = p_in >> HASH_SHIFT;
        h     = p_in[SIGNATURE_LEN-1:0] ^ p_shr[SIGNATURE_LEN-1:0];
        if (h == SIG_ALL) begin
            h = SIG_ALL - SIGNATURE_LEN'(1);
        end
        s3_d       = s2_q;
        s3_d.value = PACK_VALUE_W'(h);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign valid_o     = s3_q.valid;
    assign last_o      = s3_q.last;
    assign index_o     = s3_q.index[INDICE_LEN-1:0];
    assign sig_o       = s3_q.value[SIGNATURE_LEN-1:0];
    assign unused_pack = ^{s1_q, s2_q, s3_q};

endmodule

// File: rtl/proj_hasher.sv
// Hasher stage feeding the min-k sorter: per-frame index counter, sticky
// overflow flag and idle-value output mux around the hash pipeline.
module proj_hasher #(
    parameter int unsigned              DATA_LEN      = 32,
    parameter int unsigned              SIGNATURE_LEN = proj_pkg::HASHER_SORTER_SIGNATURE,
    parameter int unsigned              INDICE_LEN    = proj_pkg::INDICE_LEN,
    parameter logic [DATA_LEN-1:0]      HASH_SEED     = DATA_LEN'(proj_pkg::HASH_SEED),
    parameter logic [SIGNATURE_LEN-1:0] HASH_MULT     = SIGNATURE_LEN'(proj_pkg::HASH_MULT),
    parameter int unsigned              HASH_SHIFT    = proj_pkg::HASH_SHIFT
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic                     in_valid,
    input  logic [DATA_LEN-1:0]      in_data,
    input  logic                     in_last,
    output logic [SIGNATURE_LEN-1:0] out_signature,
    output logic [INDICE_LEN-1:0]    out_index,
    output logic                     out_valid,
    output logic                     out_frame_done,
    output logic                     out_overflow
);
    import proj_pkg::*;

    localparam logic [INDICE_LEN-1:0] IDX_MAX = '1;

    logic [INDICE_LEN-1:0]    cnt_d, cnt_q;
    logic                     full_d, full_q;
    logic [2:0]               ovf_d, ovf_q;
    logic                     seen_d, seen_q;
    logic                     pipe_valid;
    logic                     pipe_last;
    logic [INDICE_LEN-1:0]    pipe_idx;
    logic [SIGNATURE_LEN-1:0] pipe_sig;

    // full_q marks a frame that already used index max; any further word overflows.
    always_comb begin
        cnt_d  = cnt_q;
        full_d = full_q;
        if (in_valid) begin
            if (in_last) begin
                cnt_d  = '0;
                full_d = 1'b0;
            end else if (cnt_q == IDX_MAX) begin
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + INDICE_LEN'(1);
            end
        end
        ovf_d  = {ovf_q[1:0], in_valid & full_q};
        seen_d = seen_q | ovf_q[2];
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
            ovf_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
            seen_q <= seen_d;
        end
    end

    proj_hash_pipe #(
        .DATA_LEN      (DATA_LEN),
        .SIGNATURE_LEN (SIGNATURE_LEN),
        .INDICE_LEN    (INDICE_LEN),
        .HASH_SEED     (HASH_SEED),
        .HASH_MULT     (HASH_MULT),
        .HASH_SHIFT    (HASH_SHIFT)
    ) u_pipe (
        .clk_i   (in_clk),
        .rst_i   (in_rst),
        .valid_i (in_valid),
        .last_i  (in_last),
        .index_i (cnt_q),
        .data_i  (in_data),
        .valid_o (pipe_valid),
        .last_o  (pipe_last),
        .index_o (pipe_idx),
        .sig_o   (pipe_sig)
    );

    assign out_valid      = pipe_valid;
    assign out_signature  = pipe_valid ? pipe_sig : '1;
    assign out_index      = pipe_valid ? pipe_idx : '0;
    assign out_frame_done = pipe_valid & pipe_last;
    assign out_overflow   = seen_q | ovf_q[2];

endmodule

// File: tb/tb_proj_hasher.sv
// Bench for proj_hasher: identity-hash instance plus a seeded instance,
// checked every cycle against a queue-based frame/hash model.
module tb_proj_hasher;

    logic        clk;
    logic        in_rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;

    logic [15:0] a_sig, b_sig;
    logic [3:0]  a_idx, b_idx;
    logic        a_valid, b_valid;
    logic        a_done, b_done;
    logic        a_ovf, b_ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          valid;
        bit          last;
        int          idx;
        bit          offend;
        logic [15:0] data;
    } ent_t;

    ent_t q[$];
    int   cnt;
    bit   ovf_m;

    proj_hasher #(
        .DATA_LEN(16), .SIGNATURE_LEN(16), .INDICE_LEN(4),
        .HASH_SEED(16'h0000), .HASH_MULT(16'h0001), .HASH_SHIFT(16)
    ) dut_a (
        .in_clk(clk), .in_rst(in_rst), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last),
        .out_signature(a_sig), .out_index(a_idx), .out_valid(a_valid),
        .out_frame_done(a_done), .out_overflow(a_ovf)
    );

    proj_hasher #(
        .DATA_LEN(16), .SIGNATURE_LEN(16), .INDICE_LEN(4),
        .HASH_SEED(16'h00FF), .HASH_MULT(16'h0003), .HASH_SHIFT(8)
    ) dut_b (
        .in_clk(clk), .in_rst(in_rst), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last),
        .out_signature(b_sig), .out_index(b_idx), .out_valid(b_valid),
        .out_frame_done(b_done), .out_overflow(b_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_hash(input logic [15:0] d,
                                             input longint unsigned seed,
                                             input longint unsigned mult,
                                             input int shift);
        longint unsigned x, p, h;
        x = (longint'(d) ^ seed) & 64'hFFFF;
        p = x * mult;
        h = (p ^ (p >> shift)) & 64'hFFFF;
        if (h == 64'hFFFF) h = 64'hFFFE;
        return h[15:0];
    endfunction

    function automatic ent_t idle_ent();
        ent_t e;
        e.valid = 0; e.last = 0; e.idx = 0; e.offend = 0; e.data = '0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        q.push_back(idle_ent());
        q.push_back(idle_ent());
        cnt   = 0;
        ovf_m = 0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_a_valid"}, a_valid, 0);
        chk({tag, "_a_sig"},   a_sig,   16'hFFFF);
        chk({tag, "_a_idx"},   a_idx,   0);
        chk({tag, "_a_done"},  a_done,  0);
        chk({tag, "_a_ovf"},   a_ovf,   0);
        chk({tag, "_b_valid"}, b_valid, 0);
        chk({tag, "_b_sig"},   b_sig,   16'hFFFF);
    endtask

    task automatic compare();
        ent_t        e;
        logic [15:0] ea, eb;
        logic [3:0]  ei;
        e = q.pop_front();
        if (e.valid && e.offend) ovf_m = 1;
        ea = e.valid ? ref_hash(e.data, 0, 1, 16) : 16'hFFFF;
        eb = e.valid ? ref_hash(e.data, 64'h00FF, 3, 8) : 16'hFFFF;
        ei = e.valid ? 4'(e.idx) : 4'd0;
        chk("a_valid", a_valid, e.valid);
        chk("a_sig",   a_sig,   ea);
        chk("a_idx",   a_idx,   ei);
        chk("a_done",  a_done,  e.valid && e.last);
        chk("a_ovf",   a_ovf,   ovf_m);
        chk("b_valid", b_valid, e.valid);
        chk("b_sig",   b_sig,   eb);
        chk("b_idx",   b_idx,   ei);
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic l);
        ent_t e;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        e = idle_ent();
        if (v) begin
            e.valid  = 1;
            e.last   = l;
            e.data   = d;
            e.idx    = (cnt > 15) ? 15 : cnt;
            e.offend = (cnt >= 16);
            cnt      = l ? 0 : cnt + 1;
        end
        q.push_back(e);
        #1;
        compare();
    endtask

    initial begin
        logic [15:0] rd;
        logic        rv, rl;
        clk      = 0;
        in_rst   = 1;
        in_valid = 0;
        in_data  = '0;
        in_last  = 0;
        model_reset();
        #2;
        check_idle("reset");
        @(posedge clk);
        #1;
        in_rst = 0;

        step(1, 16'h0005, 0);
        step(1, 16'h0003, 0);
        step(1, 16'h0009, 1);

        step(1, 16'h0011, 0);
        step(0, 16'h1234, 1);
        step(1, 16'h0022, 0);

        step(1, 16'hFFFF, 1);

        step(1, 16'h00A1, 0);
        step(1, 16'h00A2, 1);
        step(1, 16'h00B1, 0);
        step(1, 16'h00B2, 0);
        step(1, 16'h00B3, 1);

        for (int i = 0; i < 80; i++) begin
            rv = ($urandom_range(0, 9) < 7);
            rl = ($urandom_range(0, 4) == 0);
            rd = 16'($urandom);
            step(rv, rd, rl);
        end
        rd = 16'($urandom);
        step(1, rd, 1);

        for (int i = 0; i < 17; i++) begin
            step(1, 16'(i * 16'h0101 + 7), 0);
        end
        for (int i = 0; i < 3; i++) step(0, 16'h0000, 0);

        step(1, 16'h1111, 0);
        step(1, 16'h2222, 0);
        in_rst = 1;
        #1;
        check_idle("rst_async");
        model_reset();
        @(posedge clk);
        #1;
        in_rst = 0;
        for (int i = 0; i < 3; i++) step(0, 16'h0000, 0);

        step(1, 16'h0101, 1);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        chk("seeded_hash", b_sig, 16'h05FF);
        chk("ident_hash",  a_sig, 16'h0101);
        chk("post_rst_idx", a_idx, 0);
        step(0, 16'h0000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
